// File: rtl/font_pkg.sv
// Shared glyph codes, font geometry and pipeline types. Used by the renderer,
// the font ROM and the controller that writes text.
package font_pkg;

  localparam int GLYPH_W     = 8;
  localparam int GLYPH_ROWS  = 16;
  localparam int FONT_ADDR_W = 6;
  localparam int COL_W       = $clog2(GLYPH_W);
  localparam int ROW_W       = $clog2(GLYPH_ROWS);

  typedef logic [1:0] glyph_t;

  localparam glyph_t GLYPH_NULL  = 2'd0;
  localparam glyph_t GLYPH_F     = 2'd1;
  localparam glyph_t GLYPH_H     = 2'd2;
  localparam glyph_t GLYPH_BLANK = 2'd3;

  // Per-pixel information carried alongside the registered ROM address.
  typedef struct packed {
    logic             video_on;
    logic             in_region;
    logic [COL_W-1:0] col;
  } stage1_t;

  // The ROM is organised as one 16-row block per glyph code.
  function automatic logic [FONT_ADDR_W-1:0] font_row_addr(glyph_t code, logic [ROW_W-1:0] row);
    return {code, row};
  endfunction

endpackage

// File: rtl/text_char_buffer.sv
// Writable line buffer of glyph codes with a combinational read port.
module text_char_buffer
  import font_pkg::*;
#(
  parameter int N_CHARS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  logic [1:0] wr_code,
  input  logic [3:0] rd_idx,
  output logic [1:0] rd_code
);

  glyph_t slot_q [N_CHARS];

  // Slot registers; an index beyond the line matches no slot, so it is a no-op.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this is a handful of flops, not a RAM, so every slot is reset;
      // a RAM-mapped array would have to be left unreset and cleared by writes.
      for (int i = 0; i < N_CHARS; i++) slot_q[i] <= GLYPH_NULL;
    end else if (wr_en) begin
      for (int i = 0; i < N_CHARS; i++) begin
        // NOTE: non-blocking so a same-cycle reader still sees the old code.
        if (wr_idx == 4'(i)) slot_q[i] <= wr_code;
      end
    end
  end

  // Read mux by character index; out-of-line indices read as the null glyph.
  always_comb begin
    // NOTE: default assigned first, otherwise the unmatched case infers a latch.
    rd_code = GLYPH_NULL;
    for (int i = 0; i < N_CHARS; i++) begin
      if (rd_idx == 4'(i)) rd_code = slot_q[i];
    end
  end

endmodule

// File: rtl/font_text_renderer.sv
// Text-line renderer: scan position -> font ROM row address -> pixel mask and
// colour, two registers deep, with an optional free-running blink.
module font_text_renderer
  import font_pkg::*;
#(
  parameter int          N_CHARS   = 8,
  parameter int          X0        = 16,
  parameter int          Y0        = 32,
  parameter logic [11:0] FG_RGB    = 12'hFFF,
  parameter logic [11:0] BG_RGB    = 12'h000,
  parameter int          BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [1:0]  wr_code,
  input  logic        blink_en,
  output logic [5:0]  font_addr,
  input  logic [7:0]  font_data,
  output logic        text_on,
  output logic [11:0] rgb
);

  localparam int X_END = X0 + GLYPH_W * N_CHARS;
  localparam int Y_END = Y0 + GLYPH_ROWS;
  localparam int CNT_W = $clog2(BLINK_DIV);

  // Stage 0: offsets into the line. Only the low bits matter for idx/col/row,
  // and low bits of a difference depend only on low bits of the operands.
  logic [6:0]       dx;
  logic [ROW_W-1:0] dy;
  logic             in_region;
  logic [3:0]       char_idx;
  glyph_t           char_code;

  assign dx        = pixel_x[6:0] - 7'(X0);
  assign dy        = pixel_y[ROW_W-1:0] - ROW_W'(Y0);
  assign char_idx  = dx[6:3];
  assign in_region = (int'(pixel_x) >= X0) && (int'(pixel_x) < X_END) &&
                     (int'(pixel_y) >= Y0) && (int'(pixel_y) < Y_END);

  text_char_buffer #(.N_CHARS(N_CHARS)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_code (wr_code),
    .rd_idx  (char_idx),
    .rd_code (char_code)
  );

  // Stage 1 next-state: ROM address and the flags that travel with it.
  logic [FONT_ADDR_W-1:0] font_addr_d, font_addr_q;
  stage1_t                s1_d, s1_q;

  always_comb begin
    font_addr_d     = in_region ? font_row_addr(char_code, dy) : '0;
    s1_d.video_on   = video_on;
    s1_d.in_region  = in_region;
    s1_d.col        = dx[COL_W-1:0];
  end

  // Stage 1 registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      font_addr_q <= '0;
      s1_q        <= '0;
    end else begin
      font_addr_q <= font_addr_d;
      s1_q        <= s1_d;
    end
  end

  // Blink timebase next-state: wrap at BLINK_DIV-1 and flip the phase.
  logic [CNT_W-1:0] blink_cnt_d, blink_cnt_q;
  logic             blink_phase_d, blink_phase_q;

  always_comb begin
    blink_cnt_d   = blink_cnt_q + CNT_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Blink registers; free-running so enabling blink never restarts the phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Stage 2 next-state: pick the glyph bit (MSB is leftmost, so bit ~col).
  logic        pix;
  logic        text_on_d, text_on_q;
  logic [11:0] rgb_d, rgb_q;

  always_comb begin
    pix       = s1_q.in_region && font_data[~s1_q.col] && !(blink_en && blink_phase_q);
    text_on_d = s1_q.video_on && pix;
    rgb_d     = !s1_q.video_on ? 12'h000 : (pix ? FG_RGB : BG_RGB);
  end

  // Stage 2 registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      text_on_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      text_on_q <= text_on_d;
      rgb_q     <= rgb_d;
    end
  end

  assign font_addr = font_addr_q;
  assign text_on   = text_on_q;
  assign rgb       = rgb_q;

endmodule
